univ_shift_seq_nbit: RTL and testbench
======================================

UNIV_SHIFT_SEQ_NBIT -- requirements
Module: univ_shift_seq_nbit

Interface
REQ-001 Parameter N, default 8, register width in bits (N >= 2).
REQ-002 Parameter AW, default 4, width of shift-amount field.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 set  input  1  synchronous preset, active-high, forces all ones.
REQ-006 start  input  1  operation request, sampled only in IDLE.
REQ-007 op  input  3  operation code, sampled with start.
REQ-008 amt  input  AW  shift/rotate step count, sampled with start.
REQ-009 ls  input  1  serial fill bit for left shift, sampled every step.
REQ-010 rs  input  1  serial fill bit for logical right shift, sampled every step.
REQ-011 reg_in  input  N  parallel load data, sampled with start.
REQ-012 reg_out  output  N  register contents.
REQ-013 so  output  1  last bit shifted or rotated out.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 Priority each edge: clr > set > FSM operation.
REQ-017 FSM states: IDLE, RUN, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-018 IDLE with start=1: latch op, amt into internal registers; step counter <= amt.
REQ-019 op 000 LOAD: reg_out <= reg_in on the accepting edge; next state DONE.
REQ-020 op 001 SLL: per step reg_out <= {reg_out[N-2:0], ls}; so <= old reg_out[N-1].
REQ-021 op 010 SRL: per step reg_out <= {rs, reg_out[N-1:1]}; so <= old reg_out[0].
REQ-022 op 011 SRA: per step reg_out <= {reg_out[N-1], reg_out[N-1:1]}; so <= old reg_out[0].
REQ-023 op 100 ROL: per step reg_out <= {reg_out[N-2:0], reg_out[N-1]}; so <= old reg_out[N-1].
REQ-024 op 101 ROR: per step reg_out <= {reg_out[0], reg_out[N-1:1]}; so <= old reg_out[0].
REQ-025 op 110 HOLD and op 111 (reserved): no register change; next state DONE.
REQ-026 Shift/rotate ops with amt != 0: next state RUN; no register change on accepting edge.
REQ-027 Shift/rotate ops with amt == 0: no register change; next state DONE.
REQ-028 RUN: exactly one step per cycle; counter decrements; on the edge performing the last step, next state DONE.
REQ-029 Latency: amt = k > 0 gives k step edges after accept; done high in the cycle following the k-th step.
REQ-030 amt > N is legal: steps continue, so SLL/SRL fully fill, ROL/ROR wrap modulo N.
REQ-031 DONE lasts exactly one cycle, then IDLE; start in DONE or RUN is ignored, not queued.
REQ-032 op, amt, reg_in changes after accept have no effect; ls/rs are used live per step.
REQ-033 so holds its value outside step edges; LOAD and HOLD do not change so.
REQ-034 set (clr low): reg_out <= all ones, state <= IDLE, done not pulsed, so unchanged; aborts any RUN.

Reset
REQ-035 clr=1 at edge: reg_out <= 0, so <= 0, counter <= 0, state <= IDLE; busy=0, done=0 next cycle.
REQ-036 clr mid-RUN aborts the operation; no done pulse is produced for it.
REQ-037 start coincident with clr or set is discarded.

Verification (N=8, AW=4)
REQ-038 clr=1 any state -> after next edge reg_out=0x00, so=0, busy=0, done=0.
REQ-039 LOAD 0xA5, then SLL amt=3 ls=0 -> reg_out 0x4A, 0x94, 0x28 on successive edges; so 1, 0, 1; done high one cycle after third step.
REQ-040 LOAD 0x90, SRA amt=2 -> reg_out 0xC8, 0xE4; so 0, 0; busy high 3 cycles total.
REQ-041 LOAD 0x3C, ROR amt=8 with start pulsed during RUN -> reg_out 0x3C at done; extra starts ignored; exactly one done pulse.
REQ-042 SRL amt=0 on 0x5A -> reg_out stays 0x5A; done in cycle after accept; busy high one cycle.
REQ-043 ROL amt=5 on 0x81, clr at second step -> reg_out 0x00, IDLE, no done; repeat with set -> reg_out 0xFF, IDLE, no done.

Source files
------------

// File: rtl/univ_shift_seq_nbit_if.sv
// -----------------------------------------------------------------------------
// univ_shift_seq_nbit_if
//   Bundles the control, data and status signals of univ_shift_seq_nbit.
//   clk and clr are left as plain ports on the module itself.
//
//   Parameters
//     N   : register width in bits
//     AW  : width of the shift-amount field
//
//   Signals (direction seen from the shifter, i.e. the slave modport)
//     set     in   synchronous preset to all ones
//     start   in   operation request, only honoured while idle
//     op      in   operation code, captured with start
//     amt     in   step count, captured with start
//     ls      in   serial fill bit for SLL, read live on every step
//     rs      in   serial fill bit for SRL, read live on every step
//     reg_in  in   parallel load data, captured with start
//     reg_out out  register contents
//     so      out  last bit shifted or rotated out
//     busy    out  high whenever an operation is in progress
//     done    out  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface univ_shift_seq_nbit_if #(
   parameter int N  = 8,
   parameter int AW = 4
);
   logic          set;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] amt;
   logic          ls;
   logic          rs;
   logic [N-1:0]  reg_in;
   logic [N-1:0]  reg_out;
   logic          so;
   logic          busy;
   logic          done;

   modport master (
      output set, start, op, amt, ls, rs, reg_in,
      input  reg_out, so, busy, done
   );

   modport slave (
      input  set, start, op, amt, ls, rs, reg_in,
      output reg_out, so, busy, done
   );
endinterface

// File: rtl/univ_shift_seq_nbit.sv
// -----------------------------------------------------------------------------
// univ_shift_seq_nbit
//   Sequential universal shift register. An accepted request either loads,
//   holds, or performs a multi-cycle shift/rotate of one bit position per
//   clock, then pulses done for one cycle.
//
//   Parameters
//     N   : register width in bits (N >= 2)
//     AW  : width of the shift-amount field (must match the interface)
//
//   Ports
//     clk : sole clock, rising edge
//     clr : synchronous active-high reset (highest priority)
//     bus : univ_shift_seq_nbit_if slave modport (see interface header)
//
//   Edge priority: clr > set > FSM.
// -----------------------------------------------------------------------------
module univ_shift_seq_nbit #(
   parameter int N  = 8,
   parameter int AW = 4
) (
   input logic                   clk,
   input logic                   clr,
   univ_shift_seq_nbit_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_SRL  = 3'b010;
   localparam logic [2:0] OP_SRA  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;

   logic [1:0]    state_q, state_d;
   logic [2:0]    op_q,    op_d;
   logic [AW-1:0] cnt_q,   cnt_d;
   logic [N-1:0]  reg_q,   reg_d;
   logic          so_q,    so_d;

   logic          is_shift;

   // SLL..ROR occupy a contiguous code range; everything else finishes at once.
   assign is_shift = (bus.op >= OP_SLL) && (bus.op <= OP_ROR);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      reg_d   = reg_q;
      so_d    = so_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d  = bus.op;
               cnt_d = bus.amt;
               if (bus.op == OP_LOAD) begin
                  reg_d   = bus.reg_in;
                  state_d = DONE;
               end else if (is_shift && (bus.amt != '0)) begin
                  state_d = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end

         RUN: begin
            case (op_q)
               OP_SLL: begin
                  reg_d = {reg_q[N-2:0], bus.ls};
                  so_d  = reg_q[N-1];
               end
               OP_SRL: begin
                  reg_d = {bus.rs, reg_q[N-1:1]};
                  so_d  = reg_q[0];
               end
               OP_SRA: begin
                  reg_d = {reg_q[N-1], reg_q[N-1:1]};
                  so_d  = reg_q[0];
               end
               OP_ROL: begin
                  reg_d = {reg_q[N-2:0], reg_q[N-1]};
                  so_d  = reg_q[N-1];
               end
               OP_ROR: begin
                  reg_d = {reg_q[0], reg_q[N-1:1]};
                  so_d  = reg_q[0];
               end
               default: begin
               end
            endcase
            cnt_d = cnt_q - 1'b1;
            // Counter still holds the remaining step count, so 1 means this
            // edge performs the final step.
            if (cnt_q == AW'(1)) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         reg_q   <= '0;
         so_q    <= 1'b0;
      end else if (bus.set) begin
         // Preset aborts any operation silently; so keeps its last value.
         state_q <= IDLE;
         cnt_q   <= '0;
         reg_q   <= '1;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         reg_q   <= reg_d;
         so_q    <= so_d;
      end
   end

   assign bus.reg_out = reg_q;
   assign bus.so      = so_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_univ_shift_seq_nbit.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_seq_nbit
//   Directed and randomized checks of univ_shift_seq_nbit (N=8, AW=4) against
//   an arithmetic reference model of each shift/rotate step.
// -----------------------------------------------------------------------------
module tb_univ_shift_seq_nbit;

   logic clk;
   logic clr;

   univ_shift_seq_nbit_if #(.N(8), .AW(4)) bus ();

   univ_shift_seq_nbit #(.N(8), .AW(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   logic [7:0] exp_reg;
   logic       exp_so;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One step of the operation, computed with integer arithmetic on the value.
   function automatic logic [7:0] ref_step(input logic [2:0] op, input int v,
                                           input int l, input int r,
                                           input logic so_in, output logic so_o);
      int nv;
      nv   = v;
      so_o = so_in;
      case (op)
         3'd1: begin nv = (v * 2) % 256 + l;                      so_o = (v >= 128);    end
         3'd2: begin nv = v / 2 + r * 128;                        so_o = (v % 2) == 1;  end
         3'd3: begin nv = v / 2 + ((v >= 128) ? 128 : 0);         so_o = (v % 2) == 1;  end
         3'd4: begin nv = (v * 2) % 256 + v / 128;                so_o = (v >= 128);    end
         3'd5: begin nv = v / 2 + (v % 2) * 128;                  so_o = (v % 2) == 1;  end
         default: begin end
      endcase
      return nv[7:0];
   endfunction

   // Issue one request and follow it to IDLE, checking every cycle.
   task automatic run_op(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din,
                         input bit noise, input bit randfill);
      int   k;
      logic nso;
      bus.op     = op;
      bus.amt    = amt;
      bus.reg_in = din;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      if (op == 3'd0) exp_reg = din;
      k = (op >= 3'd1 && op <= 3'd5) ? int'(amt) : 0;
      chk8("accept_reg", bus.reg_out, exp_reg);
      chk1("accept_so", bus.so, exp_so);
      chk1("accept_busy", bus.busy, 1'b1);
      chk1("accept_done", bus.done, (k == 0));
      for (int i = 1; i <= k; i++) begin
         bus.ls = randfill ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.rs = randfill ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            bus.start  = 1'($urandom_range(0, 1));
            bus.op     = 3'($urandom);
            bus.amt    = 4'($urandom);
            bus.reg_in = 8'($urandom);
         end
         exp_reg = ref_step(op, int'(exp_reg), int'(bus.ls), int'(bus.rs), exp_so, nso);
         exp_so  = nso;
         tick();
         chk8("step_reg", bus.reg_out, exp_reg);
         chk1("step_so", bus.so, exp_so);
         chk1("step_busy", bus.busy, 1'b1);
         chk1("step_done", bus.done, (i == k));
      end
      // Now in DONE; a start here must be dropped.
      bus.start = noise ? 1'b1 : 1'b0;
      tick();
      bus.start = 1'b0;
      chk1("idle_busy", bus.busy, 1'b0);
      chk1("idle_done", bus.done, 1'b0);
      chk8("idle_reg", bus.reg_out, exp_reg);
      chk1("idle_so", bus.so, exp_so);
   endtask

   initial begin
      clr        = 1'b1;
      bus.set    = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.amt    = 4'd0;
      bus.ls     = 1'b0;
      bus.rs     = 1'b0;
      bus.reg_in = 8'h00;
      exp_reg    = 8'h00;
      exp_so     = 1'b0;
      tick();
      tick();
      chk8("rst_reg", bus.reg_out, 8'h00);
      chk1("rst_so", bus.so, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      clr = 1'b0;
      tick();

      // LOAD then SLL x3 with zero fill
      run_op(3'd0, 4'd0, 8'hA5, 1'b0, 1'b0);
      run_op(3'd1, 4'd3, 8'h00, 1'b0, 1'b0);
      chk8("sll3_final", bus.reg_out, 8'h28);
      chk1("sll3_so", bus.so, 1'b1);

      // LOAD then SRA x2
      run_op(3'd0, 4'd0, 8'h90, 1'b0, 1'b0);
      run_op(3'd3, 4'd2, 8'h00, 1'b0, 1'b0);
      chk8("sra2_final", bus.reg_out, 8'hE4);

      // ROR by full width with start noise during RUN and DONE
      run_op(3'd0, 4'd0, 8'h3C, 1'b0, 1'b0);
      run_op(3'd5, 4'd8, 8'h00, 1'b1, 1'b0);
      chk8("ror8_final", bus.reg_out, 8'h3C);

      // SRL with zero amount, then HOLD
      run_op(3'd0, 4'd0, 8'h5A, 1'b0, 1'b0);
      run_op(3'd2, 4'd0, 8'hFF, 1'b0, 1'b0);
      chk8("srl0_final", bus.reg_out, 8'h5A);
      run_op(3'd6, 4'd7, 8'h11, 1'b0, 1'b0);
      chk8("hold_final", bus.reg_out, 8'h5A);

      // ROL x5 on 0x81 aborted by clr at the second step
      run_op(3'd0, 4'd0, 8'h81, 1'b0, 1'b0);
      bus.op = 3'd4; bus.amt = 4'd5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk8("rol_step1", bus.reg_out, 8'h03);
      chk1("rol_step1_so", bus.so, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk8("clr_abort_reg", bus.reg_out, 8'h00);
      chk1("clr_abort_so", bus.so, 1'b0);
      chk1("clr_abort_busy", bus.busy, 1'b0);
      chk1("clr_abort_done", bus.done, 1'b0);
      tick();
      chk1("clr_abort_done2", bus.done, 1'b0);
      chk1("clr_abort_busy2", bus.busy, 1'b0);

      // Same with set
      exp_reg = 8'h00; exp_so = 1'b0;
      run_op(3'd0, 4'd0, 8'h81, 1'b0, 1'b0);
      bus.op = 3'd4; bus.amt = 4'd5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.set = 1'b1;
      tick();
      bus.set = 1'b0;
      chk8("set_abort_reg", bus.reg_out, 8'hFF);
      chk1("set_abort_so", bus.so, 1'b1);
      chk1("set_abort_busy", bus.busy, 1'b0);
      chk1("set_abort_done", bus.done, 1'b0);
      tick();
      chk1("set_abort_done2", bus.done, 1'b0);

      // start coincident with clr, then with set, is discarded
      bus.op = 3'd0; bus.reg_in = 8'h77; bus.start = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0; bus.start = 1'b0;
      chk8("clr_start_reg", bus.reg_out, 8'h00);
      chk1("clr_start_busy", bus.busy, 1'b0);
      tick();
      chk1("clr_start_busy2", bus.busy, 1'b0);
      bus.start = 1'b1; bus.set = 1'b1;
      tick();
      bus.start = 1'b0; bus.set = 1'b0;
      chk8("set_start_reg", bus.reg_out, 8'hFF);
      tick();
      chk1("set_start_busy", bus.busy, 1'b0);
      chk1("set_start_done", bus.done, 1'b0);
      exp_reg = 8'hFF; exp_so = 1'b0;

      // Randomized operations, including amt > N and live serial fill
      for (int t = 0; t < 40; t++) begin
         run_op(3'($urandom_range(0, 7)), 4'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
